delay_sum_beamformer: RTL and testbench
=======================================

DELAY_SUM_BEAMFORMER -- requirements
Module: delay_sum_beamformer

Interface
REQ-001 SHALL provide parameters: SAMPLE_WIDTH, default 16, mic sample width (two's complement); DEPTH, default 16, history samples per mic (power of two).
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk_in  input  1  system clock, all state on rising edge.
REQ-004 rst_in  input  1  asynchronous active-high reset.
REQ-005 sample_valid_in  input  1  one new sample per mic is presented this cycle.
REQ-006 mic_1_in..mic_4_in  input  SAMPLE_WIDTH each  signed mic samples.
REQ-007 delay_1_in..delay_4_in  input  8 each  per-mic delay in samples, from the angle-to-delay table.
REQ-008 sum_out  output  SAMPLE_WIDTH+2  signed beamformed sample.
REQ-009 sum_valid_out  output  1  one-cycle strobe, sum_out valid.

Function
REQ-010 SHALL keep a circular history buffer of DEPTH entries per mic and a shared write pointer wr_ptr (log2(DEPTH) bits).
REQ-011 SHALL write each mic sample at wr_ptr when sample_valid_in=1, then increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-012 SHALL leave buffer and wr_ptr unchanged on cycles with sample_valid_in=0.
REQ-013 SHALL sample delay_k_in in the same cycle as sample_valid_in; delays are not held between samples.
REQ-014 SHALL clamp any delay_k_in > DEPTH-1 to DEPTH-1 before use.
REQ-015 SHALL select, for mic k, the sample accepted d_k accepted-samples earlier; d_k=0 selects the sample accepted in the current cycle (write-through forwarding, no stale read).
REQ-016 SHALL register the four selected samples in stage 1 and form their sign-extended sum in stage 2, no overflow at SAMPLE_WIDTH+2 bits.
REQ-017 SHALL assert sum_valid_out exactly 2 cycles after each cycle with sample_valid_in=1, for exactly one cycle per accepted sample.
REQ-018 SHALL accept back-to-back samples every cycle with no stall; throughput one sample per cycle.
REQ-019 SHALL read history entries never written since reset as zero.
REQ-020 SHALL allow delay changes between consecutive samples; each output uses only the delays captured with its own input sample.
REQ-021 SHALL hold sum_out at its last value when sum_valid_out=0.

Reset
REQ-022 SHALL, while rst_in=1, immediately force sum_out=0, sum_valid_out=0, wr_ptr=0, all history entries and pipeline registers to 0.
REQ-023 SHALL discard in-flight samples when reset is asserted mid-operation; no sum_valid_out pulse for them after reset release.
REQ-024 SHALL accept a sample on the first rising edge after rst_in deasserts.

Configuration
REQ-025 SHALL support macro BEAM_AVERAGE_EN.
REQ-026 With BEAM_AVERAGE_EN defined, sum_out SHALL equal the four-sample sum arithmetically shifted right by 2 (floor), sign-extended to SAMPLE_WIDTH+2; latency unchanged.
REQ-027 Without BEAM_AVERAGE_EN, sum_out SHALL equal the full four-sample sum.

Verification
REQ-028 Reset, then all delays 0, mics 100/200/300/400 with valid for one cycle -> sum_valid_out pulses 2 cycles later, sum_out=1000 (250 with BEAM_AVERAGE_EN).
REQ-029 Delays 0/5/10/15, mic_k = sample index n for n=0..31 every cycle -> for n>=15 sum_out=4n-30; for n<15 missing taps contribute 0.
REQ-030 Delay 200 on mic 4 only, others 0, ramp input -> mic 4 behaves as delay 15.
REQ-031 Valid gapped (1 on, 3 off) with delay 2 on all mics -> output per valid uses samples two valid-samples earlier; gaps do not count; one strobe per valid.
REQ-032 All mics -2^(SAMPLE_WIDTH-1), delays 0 -> sum_out=-2^(SAMPLE_WIDTH+1), no wrap; all mics 2^(SAMPLE_WIDTH-1)-1 -> 2^(SAMPLE_WIDTH+1)-4.
REQ-033 Assert rst_in one cycle after a valid sample -> sum_valid_out stays 0, sum_out=0; next sample after release sees zeroed history.

Source files
------------

// File: rtl/delay_sum_beamformer.sv
// ---------------------------------------------------------------------------
// delay_sum_beamformer
//
// Four-microphone delay-and-sum beamformer. Each mic feeds a circular history
// buffer of DEPTH samples sharing one write pointer. For every accepted
// sample, the sample that is d_k accepted-samples old is picked per mic. The
// four picks are registered in stage 1 and summed with sign extension in
// stage 2. Latency is two cycles, and the design accepts one sample per cycle.
//
// Optional feature: define BEAM_AVERAGE_EN to output the four-sample average
// (sum arithmetically shifted right by 2) instead of the full sum.
//
// Parameters
//   SAMPLE_WIDTH  mic sample width, two's complement
//   DEPTH         history samples per mic (power of two)
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            asynchronous active-high reset
//   sample_valid_in   one new sample per mic this cycle
//   mic_1_in..4       signed mic samples
//   delay_1_in..4     per-mic delay in samples (clamped to DEPTH-1)
//   sum_out           signed beamformed sample, SAMPLE_WIDTH+2 bits
//   sum_valid_out     one-cycle strobe marking sum_out valid
// ---------------------------------------------------------------------------
module delay_sum_beamformer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_valid_in,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_1_in,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_2_in,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_3_in,
  input  logic signed [SAMPLE_WIDTH-1:0] mic_4_in,
  input  logic        [7:0]              delay_1_in,
  input  logic        [7:0]              delay_2_in,
  input  logic        [7:0]              delay_3_in,
  input  logic        [7:0]              delay_4_in,
  output logic signed [SAMPLE_WIDTH+1:0] sum_out,
  output logic                           sum_valid_out
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int OW = SAMPLE_WIDTH + 2;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] MAX_D = 8'(DEPTH - 1);

  // Out-of-range delays saturate to the oldest stored sample.
  function automatic logic [AW-1:0] f_clamp(input logic [7:0] d);
    if (d > MAX_D) return AW'(DEPTH - 1);
    else           return d[AW-1:0];
  endfunction

  function automatic logic signed [OW-1:0] f_scale(input logic signed [OW-1:0] s);
`ifdef BEAM_AVERAGE_EN
    return s >>> 2;
`else
    return s;
`endif
  endfunction

  logic signed [SW-1:0] w_mic [4];
  logic        [AW-1:0] w_dly [4];
  logic signed [SW-1:0] w_sel [4];
  logic signed [OW-1:0] w_sum_p1;

  logic        [AW-1:0] r_wr_ptr;
  logic signed [SW-1:0] r_hist [4][DEPTH];
  logic signed [SW-1:0] r_samp_p1 [4];
  logic                 r_vld_p1;

  assign w_mic[0] = mic_1_in;
  assign w_mic[1] = mic_2_in;
  assign w_mic[2] = mic_3_in;
  assign w_mic[3] = mic_4_in;
  assign w_dly[0] = f_clamp(delay_1_in);
  assign w_dly[1] = f_clamp(delay_2_in);
  assign w_dly[2] = f_clamp(delay_3_in);
  assign w_dly[3] = f_clamp(delay_4_in);

  // Zero delay forwards the incoming sample because it is not yet stored.
  // Otherwise the entry d slots behind the write pointer holds the sample
  // accepted d valid cycles ago. Pointer subtraction wraps modulo DEPTH.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_sel[k] = '0;
      if (w_dly[k] == '0) w_sel[k] = w_mic[k];
      else                w_sel[k] = r_hist[k][r_wr_ptr - w_dly[k]];
    end
  end

  // ---- stage 0 -> 1: history write and tap selection ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_vld_p1 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_samp_p1[k] <= '0;
        for (int i = 0; i < DEPTH; i++) r_hist[k][i] <= '0;
      end
    end else begin
      r_vld_p1 <= sample_valid_in;
      if (sample_valid_in) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        for (int k = 0; k < 4; k++) begin
          r_hist[k][r_wr_ptr] <= w_mic[k];
          r_samp_p1[k]        <= w_sel[k];
        end
      end
    end
  end

  always_comb begin
    w_sum_p1 = '0;
    for (int k = 0; k < 4; k++)
      w_sum_p1 = w_sum_p1 + {{2{r_samp_p1[k][SW-1]}}, r_samp_p1[k]};
  end

  // ---- stage 1 -> 2: sum and output register ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_out       <= '0;
      sum_valid_out <= 1'b0;
    end else begin
      sum_valid_out <= r_vld_p1;
      if (r_vld_p1) sum_out <= f_scale(w_sum_p1);
    end
  end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
module tb_delay_sum_beamformer;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic               sample_valid_in = 1'b0;
  logic signed [15:0] mic_1_in = '0, mic_2_in = '0, mic_3_in = '0, mic_4_in = '0;
  logic        [7:0]  delay_1_in = '0, delay_2_in = '0, delay_3_in = '0, delay_4_in = '0;
  logic signed [17:0] sum_out;
  logic               sum_valid_out;

  int checks = 0;
  int errors = 0;

  // expectation for the sample driven in the previous step
  logic               prev_v = 1'b0;
  logic signed [17:0] prev_s = '0;
  logic signed [17:0] held_s = '0;

  delay_sum_beamformer #(.SAMPLE_WIDTH(16), .DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
    .mic_1_in(mic_1_in), .mic_2_in(mic_2_in), .mic_3_in(mic_3_in), .mic_4_in(mic_4_in),
    .delay_1_in(delay_1_in), .delay_2_in(delay_2_in),
    .delay_3_in(delay_3_in), .delay_4_in(delay_4_in),
    .sum_out(sum_out), .sum_valid_out(sum_valid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic signed [17:0] scale(input int s);
    logic signed [17:0] v;
    v = 18'(s);
`ifdef BEAM_AVERAGE_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

  task automatic chk_v(input string tag, input logic exp);
    checks++;
    assert (sum_valid_out === exp) else begin
      errors++;
      $error("FAIL %s sum_valid_out observed=%b expected=%b", tag, sum_valid_out, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic signed [17:0] exp);
    checks++;
    assert (sum_out === exp) else begin
      errors++;
      $error("FAIL %s sum_out observed=%0d expected=%0d", tag, sum_out, exp);
    end
  endtask

  // Drive one cycle, then check the output belonging to the previous step.
  // raw_sum is the full four-sample sum expected for this step's sample.
  task automatic step(input string tag, input logic v,
                      input int m1, input int m2, input int m3, input int m4,
                      input int d1, input int d2, input int d3, input int d4,
                      input int raw_sum);
    sample_valid_in = v;
    mic_1_in = 16'(m1); mic_2_in = 16'(m2); mic_3_in = 16'(m3); mic_4_in = 16'(m4);
    delay_1_in = 8'(d1); delay_2_in = 8'(d2); delay_3_in = 8'(d3); delay_4_in = 8'(d4);
    @(posedge clk_in);
    #1;
    chk_v(tag, prev_v);
    if (prev_v) held_s = prev_s;
    chk_s(tag, held_s);
    prev_v = v;
    prev_s = scale(raw_sum);
    sample_valid_in = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_in = 1'b1;
    #1;
    chk_v(tag, 1'b0);
    chk_s(tag, 18'sd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    prev_v = 1'b0;
    held_s = '0;
  endtask

  initial begin
    int e;
    int d [4];

    do_reset("reset_init");

    // single impulse, all delays zero
    step("impulse", 1'b1, 100, 200, 300, 400, 0, 0, 0, 0, 1000);
    step("impulse_out", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("impulse_once", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("impulse_hold", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ramp with staggered delays 0/5/10/15
    do_reset("reset_ramp");
    d = '{0, 5, 10, 15};
    for (int n = 0; n < 32; n++) begin
      e = 0;
      for (int k = 0; k < 4; k++) if (n >= d[k]) e += n - d[k];
      step("ramp_stagger", 1'b1, n, n, n, n, 0, 5, 10, 15, e);
    end
    step("ramp_stagger_tail", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // oversize delay on mic 4 clamps to 15
    do_reset("reset_clamp");
    for (int n = 0; n < 20; n++) begin
      e = 3 * n + ((n >= 15) ? n - 15 : 0);
      step("clamp200", 1'b1, n, n, n, n, 0, 0, 0, 200, e);
    end
    step("clamp_tail", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // gapped valid, delay 2: gaps do not advance history
    do_reset("reset_gap");
    for (int j = 0; j < 6; j++) begin
      e = (j >= 2) ? 4 * 10 * (j - 1) : 0;
      step("gap_valid", 1'b1, 10 * (j + 1), 10 * (j + 1), 10 * (j + 1), 10 * (j + 1), 2, 2, 2, 2, e);
      for (int g = 0; g < 3; g++)
        step("gap_idle", 1'b0, 999, 999, 999, 999, 0, 0, 0, 0, 0);
    end

    // extremes, no wrap
    step("min_val", 1'b1, -32768, -32768, -32768, -32768, 0, 0, 0, 0, -131072);
    step("max_val", 1'b1, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 131068);
    step("mixed", 1'b1, 32767, -32768, 1, -1, 0, 0, 0, 0, -1);
    step("extreme_tail", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with a sample in flight
    step("flight_pre", 1'b1, 5, 5, 5, 5, 0, 0, 0, 0, 20);
    do_reset("reset_flight");
    step("flight_gone1", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("flight_gone2", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst_a", 1'b1, 7, 7, 7, 7, 1, 1, 1, 1, 0);
    step("post_rst_b", 1'b1, 9, 9, 9, 9, 1, 1, 1, 1, 28);
    step("post_rst_tail", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst_idle", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
